// File: rtl/xor_net_driver_if.sv
// xor_net_driver_if: host stream, network and result signals of the XOR network driver
interface xor_net_driver_if #(parameter int DATA_WIDTH = 8);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_x1;
  logic [DATA_WIDTH-1:0] in_x2;
  logic                  net_En;
  logic                  net_Run;
  logic [DATA_WIDTH-1:0] net_X1;
  logic [DATA_WIDTH-1:0] net_X2;
  logic [DATA_WIDTH-1:0] net_Y1;
  logic [1:0]            net_Ready_Bus;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_y;
  logic                  out_err;
  logic                  busy;
  logic [15:0]           done_count;
  modport master (
    input  in_valid, in_x1, in_x2, net_Y1, net_Ready_Bus, out_ready,
    output in_ready, net_En, net_Run, net_X1, net_X2, out_valid, out_y, out_err, busy, done_count
  );
  modport slave (
    output in_valid, in_x1, in_x2, net_Y1, net_Ready_Bus, out_ready,
    input  in_ready, net_En, net_Run, net_X1, net_X2, out_valid, out_y, out_err, busy, done_count
  );
endinterface

// File: rtl/xor_net_driver.sv
// xor_net_driver: queues operand pairs and runs them one at a time through the XOR network
module xor_net_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 255
) (
  input logic clk,
  input logic rst,
  xor_net_driver_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem_x1 [DEPTH];
  logic [DATA_WIDTH-1:0] mem_x2 [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic [TW-1:0] timer;
  logic alive, full, push, pop, rdy, tmo, take;
  assign full          = cnt == (AW+1)'(DEPTH);
  assign bus.in_ready  = alive && !full;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = state == IDLE && cnt != 0;
  assign rdy           = timer != 0 && bus.net_Ready_Bus[1];
  assign tmo           = timer == TW'(TIMEOUT);
  assign take          = bus.out_valid && bus.out_ready;
  assign bus.net_En    = state == LAUNCH || state == WAIT;
  assign bus.net_Run   = state == LAUNCH;
  assign bus.out_valid = state == HOLD;
  assign bus.busy      = state != IDLE || cnt != 0;
  // next-state sequencing of one network run
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = pop ? LAUNCH : IDLE;
      LAUNCH:  state_nx = WAIT;
      WAIT:    state_nx = (rdy || tmo) ? HOLD : WAIT;
      default: state_nx = bus.out_ready ? IDLE : HOLD;
    endcase
  end
  // FIFO storage, written without reset since occupancy is tracked by cnt
  always_ff @(posedge clk) begin
    if (push) begin
      mem_x1[wr_ptr] <= bus.in_x1;
      mem_x2[wr_ptr] <= bus.in_x2;
    end
  end
  // state, FIFO pointers, operand/result registers and counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      alive          <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      cnt            <= '0;
      timer          <= '0;
      bus.net_X1     <= '0;
      bus.net_X2     <= '0;
      bus.out_y      <= '0;
      bus.out_err    <= 1'b0;
      bus.done_count <= '0;
    end else begin
      state <= state_nx;
      alive <= 1'b1;
      cnt   <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      timer <= state == WAIT ? timer + 1'b1 : '0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        bus.net_X1 <= mem_x1[rd_ptr];
        bus.net_X2 <= mem_x2[rd_ptr];
      end
      if (state == WAIT && (rdy || tmo)) begin
        bus.out_y   <= rdy ? bus.net_Y1 : '0;
        bus.out_err <= !rdy;
      end
      if (take) bus.done_count <= bus.done_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_xor_net_driver.sv
// tb_xor_net_driver: directed checks of the XOR network driver against a small network model
module tb_xor_net_driver;
  localparam int DW = 8;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  xor_net_driver_if #(.DATA_WIDTH(DW)) bus ();
  xor_net_driver #(.DATA_WIDTH(DW), .DEPTH(4), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  int cyc = 0, run_cyc = 0, run_cnt = 0, vcount = 0, k = -1, lat = 0;
  int d, r0, v0;
  logic hold_hi = 1'b0, use_fix = 1'b0, rb;
  logic [7:0] fix_y = 8'h00;
  logic [7:0] ax [6];
  logic [7:0] bx [6];
  assign bus.net_Y1 = use_fix ? fix_y : bus.net_X1 ^ bus.net_X2;
  assign rb = hold_hi || (lat > 0 && k == lat);
  assign bus.net_Ready_Bus = {rb, rb};
  always @(posedge clk) cyc <= cyc + 1;
  // network model: counts cycles since the last Run pulse
  always @(negedge clk) begin
    k <= bus.net_Run ? 0 : (k >= 0 ? k + 1 : k);
    if (bus.net_Run) begin
      run_cyc <= cyc;
      run_cnt <= run_cnt + 1;
    end
    if (bus.out_valid) vcount <= vcount + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_x1 = a;
    bus.in_x2 = b;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("push_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_valid(output int dl);
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) chk("valid_timeout", 0, 1);
    dl = cyc - run_cyc;
  endtask
  task automatic reset_pulse();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_x1 = '0;
    bus.in_x2 = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done_count), 0);
    chk("rst_run", 32'(bus.net_Run), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready), 1);
    use_fix = 1'b1;
    fix_y = 8'h3C;
    lat = 5;
    r0 = run_cnt;
    push(8'h40, 8'h00);
    wait_valid(d);
    chk("t1_latency", 32'(d), 6);
    chk("t1_runs", 32'(run_cnt - r0), 1);
    chk("t1_y", 32'(bus.out_y), 32'h3C);
    chk("t1_err", 32'(bus.out_err), 0);
    repeat (2) @(negedge clk);
    chk("t1_hold_valid", 32'(bus.out_valid), 1);
    chk("t1_hold_y", 32'(bus.out_y), 32'h3C);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t1_done", 32'(bus.done_count), 1);
    chk("t1_valid_drop", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    reset_pulse();
    use_fix = 1'b0;
    lat = 3;
    for (int i = 0; i < 6; i++) begin
      ax[i] = 8'(i * 17 + 1);
      bx[i] = 8'(i * 3 + 80);
    end
    for (int i = 0; i < 5; i++) push(ax[i], bx[i]);
    chk("t2_full_in_ready", 32'(bus.in_ready), 0);
    chk("t2_busy", 32'(bus.busy), 1);
    bus.out_ready = 1'b1;
    fork
      push(ax[5], bx[5]);
      for (int i = 0; i < 6; i++) begin
        int dd;
        wait_valid(dd);
        chk("t2_order_y", 32'(bus.out_y), 32'(ax[i] ^ bx[i]));
        @(negedge clk);
      end
    join
    chk("t2_done", 32'(bus.done_count), 6);
    lat = 0;
    push(8'h12, 8'h34);
    wait_valid(d);
    chk("t3_latency", 32'(d), TO + 2);
    chk("t3_y", 32'(bus.out_y), 0);
    chk("t3_err", 32'(bus.out_err), 1);
    @(negedge clk);
    lat = 3;
    push(8'h55, 8'h0F);
    wait_valid(d);
    chk("t3_next_latency", 32'(d), 4);
    chk("t3_next_y", 32'(bus.out_y), 32'h5A);
    chk("t3_next_err", 32'(bus.out_err), 0);
    @(negedge clk);
    lat = 0;
    hold_hi = 1'b1;
    push(8'hC3, 8'h11);
    wait_valid(d);
    chk("t4_latency", 32'(d), 3);
    chk("t4_y", 32'(bus.out_y), 32'hD2);
    @(negedge clk);
    hold_hi = 1'b0;
    use_fix = 1'b1;
    fix_y = 8'hA5;
    lat = TO + 1;
    push(8'h01, 8'h02);
    wait_valid(d);
    chk("t5_latency", 32'(d), TO + 2);
    chk("t5_y", 32'(bus.out_y), 32'hA5);
    chk("t5_err", 32'(bus.out_err), 0);
    @(negedge clk);
    use_fix = 1'b0;
    lat = 0;
    push(8'h01, 8'h01);
    push(8'h02, 8'h02);
    push(8'h03, 8'h03);
    repeat (3) @(negedge clk);
    chk("t6_in_wait", 32'(bus.net_En), 1);
    chk("t6_done_pre", 32'(bus.done_count), 10);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(bus.out_valid), 0);
    chk("t6_run", 32'(bus.net_Run), 0);
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_done", 32'(bus.done_count), 0);
    chk("t6_in_ready", 32'(bus.in_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rel_in_ready", 32'(bus.in_ready), 1);
    v0 = vcount;
    r0 = run_cnt;
    repeat (30) @(negedge clk);
    chk("t6_no_stale_valid", 32'(vcount - v0), 0);
    chk("t6_no_stale_run", 32'(run_cnt - r0), 0);
    chk("t6_idle_busy", 32'(bus.busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
